// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// The pipeline side uses the master modport and pipe_ctrl uses the slave modport.
interface pipe_ctrl_if;
  logic       stallreq_id_i;
  logic       mc_start_i;
  logic [5:0] mc_cycles_i;
  logic       mem_req_i;
  logic       mem_ack_i;
  logic       flush_req_i;
  logic [5:0] stall_o;
  logic       flush_o;
  logic       busy_o;
  logic       timeout_o;

  modport master (
    output stallreq_id_i, mc_start_i, mc_cycles_i, mem_req_i, mem_ack_i, flush_req_i,
    input  stall_o, flush_o, busy_o, timeout_o
  );

  modport slave (
    input  stallreq_id_i, mc_start_i, mc_cycles_i, mem_req_i, mem_ack_i, flush_req_i,
    output stall_o, flush_o, busy_o, timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: prioritises memory, multi-cycle EX and ID stalls.
// Optional macro STALL_TIMEOUT_EN adds a memory-wait watchdog with a sticky timeout flag.
module pipe_ctrl #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MC_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  state_t     state_q, state_d;
  logic [5:0] mc_cnt_q, mc_cnt_d;
  logic       resume_q, resume_d;
  logic       flush_pend_q, flush_pend_d;

  logic       mem_stall_c;
  logic       flush_c;
  logic       mc_act_c;
  logic       start_c;
  logic       trip_c;
  logic       mem_supp_c;
  logic       timeout_c;
  logic [5:0] stall_c;

`ifdef STALL_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       to_flag_q;
  logic       mem_supp_q, mem_supp_d;

  // Trips on the cycle whose increment would bring the wait count to TIMEOUT_CYCLES.
  assign trip_c = mem_stall_c && (({1'b0, wait_cnt_q} + 9'd1) == {1'b0, TIMEOUT_CYCLES});

  always_comb begin
    wait_cnt_d = 8'd0;
    if (mem_stall_c && !trip_c) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    mem_supp_d = mem_supp_q;
    if (trip_c) begin
      mem_supp_d = 1'b1;
    end else if (!bus.mem_req_i) begin
      mem_supp_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= 8'd0;
      to_flag_q  <= 1'b0;
      mem_supp_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      to_flag_q  <= to_flag_q | trip_c;
      mem_supp_q <= mem_supp_d;
    end
  end

  assign mem_supp_c = mem_supp_q;
  assign timeout_c  = to_flag_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign trip_c         = 1'b0;
  assign mem_supp_c     = 1'b0;
  assign timeout_c      = 1'b0;
`endif

  assign mem_stall_c = bus.mem_req_i && !bus.mem_ack_i && !mem_supp_c;
  assign flush_c     = !mem_stall_c && (bus.flush_req_i || flush_pend_q);
  // A multi-cycle op stays live across a memory wait; resume_q remembers it.
  assign mc_act_c    = (state_q == MC_BUSY) || ((state_q == MEM_WAIT) && resume_q);
  assign start_c     = bus.mc_start_i && (bus.mc_cycles_i >= 6'd2) && !mc_act_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      mc_cnt_q     <= 6'd0;
      resume_q     <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mc_cnt_q     <= mc_cnt_d;
      resume_q     <= resume_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mc_cnt_d     = mc_cnt_q;
    resume_d     = resume_q;
    flush_pend_d = flush_pend_q;
    if (mem_stall_c) begin
      // The counter freezes; a start in this cycle still consumes its first cycle.
      state_d  = MEM_WAIT;
      resume_d = mc_act_c || start_c;
      if (start_c) begin
        mc_cnt_d = bus.mc_cycles_i - 6'd2;
      end
      if (bus.flush_req_i) begin
        flush_pend_d = 1'b1;
      end
    end else if (flush_c) begin
      state_d      = IDLE;
      mc_cnt_d     = 6'd0;
      resume_d     = 1'b0;
      flush_pend_d = 1'b0;
    end else if (start_c) begin
      state_d  = MC_BUSY;
      mc_cnt_d = bus.mc_cycles_i - 6'd2;
      resume_d = 1'b0;
    end else if (mc_act_c) begin
      resume_d = 1'b0;
      if (mc_cnt_q == 6'd0) begin
        state_d = IDLE;
      end else begin
        state_d  = MC_BUSY;
        mc_cnt_d = mc_cnt_q - 6'd1;
      end
    end else begin
      state_d  = IDLE;
      resume_d = 1'b0;
    end
    if (trip_c) begin
      flush_pend_d = 1'b1;
    end
  end

  always_comb begin
    stall_c = STALL_NONE;
    if (mem_stall_c) begin
      stall_c = STALL_MEM;
    end else if (flush_c) begin
      stall_c = STALL_NONE;
    end else if (mc_act_c || start_c) begin
      stall_c = STALL_EX;
    end else if (bus.stallreq_id_i) begin
      stall_c = STALL_ID;
    end
    bus.stall_o   = rst ? stall_c : STALL_NONE;
    bus.flush_o   = rst && flush_c;
    bus.busy_o    = rst && (state_q != IDLE);
    bus.timeout_o = rst && timeout_c;
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// against a cycle-owed behavioural model.
module tb_pipe_ctrl;
  localparam logic [7:0] TO = 8'd4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic id, input logic ms, input logic [5:0] n,
                       input logic mr, input logic ma, input logic fr);
    bus.stallreq_id_i = id;
    bus.mc_start_i    = ms;
    bus.mc_cycles_i   = n;
    bus.mem_req_i     = mr;
    bus.mem_ack_i     = ma;
    bus.flush_req_i   = fr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 6'd0, 0, 0, 0);
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic show(input string name, input int k);
    $display("[TB] %s k=%0d stall=%b flush=%b busy=%b to=%b", name, k,
             bus.stall_o, bus.flush_o, bus.busy_o, bus.timeout_o);
  endtask

  task automatic test_reset();
    drive(1, 1, 6'd5, 1, 0, 1);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      show("reset", k);
      n_tests++; if (bus.stall_o !== 6'd0) begin n_fail++; $display("FAIL reset_stall got %b exp 000000", bus.stall_o); end
      n_tests++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", bus.flush_o); end
      n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
      n_tests++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", bus.timeout_o); end
      next_cycle();
    end
    rst = 1'b1;
    drive(0, 0, 6'd0, 0, 0, 0);
    @(negedge clk);
    show("reset_release", 0);
    n_tests++; if (bus.stall_o !== 6'd0) begin n_fail++; $display("FAIL reset_release_stall got %b exp 000000", bus.stall_o); end
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got %b exp 0", bus.busy_o); end
    next_cycle();
  endtask

  task automatic test_mc_op();
    logic [5:0] es;
    logic       eb;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(0, k == 0, 6'd4, 0, 0, 0);
      es = (k < 4) ? 6'b001111 : 6'b000000;
      eb = (k >= 1 && k <= 3);
      @(negedge clk);
      show("mc_op", k);
      n_tests++; if (bus.stall_o !== es) begin n_fail++; $display("FAIL mc_op_stall k=%0d got %b exp %b", k, bus.stall_o, es); end
      n_tests++; if (bus.busy_o !== eb) begin n_fail++; $display("FAIL mc_op_busy k=%0d got %b exp %b", k, bus.busy_o, eb); end
      next_cycle();
    end
  endtask

  task automatic test_mem_stall();
    logic [5:0] es;
    logic       eb;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 6'd0, k < 4, k == 3, 0);
      es = (k < 3) ? 6'b011111 : 6'b000000;
      eb = (k >= 1 && k <= 3);
      @(negedge clk);
      show("mem_stall", k);
      n_tests++; if (bus.stall_o !== es) begin n_fail++; $display("FAIL mem_stall_stall k=%0d got %b exp %b", k, bus.stall_o, es); end
      n_tests++; if (bus.busy_o !== eb) begin n_fail++; $display("FAIL mem_stall_busy k=%0d got %b exp %b", k, bus.busy_o, eb); end
      n_tests++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL mem_stall_flush k=%0d got %b exp 0", k, bus.flush_o); end
      next_cycle();
    end
  endtask

  task automatic test_flush_pending();
    logic [5:0] es;
    logic       ef;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 6'd0, k < 2, 0, k < 2);
      es = (k < 2) ? 6'b011111 : 6'b000000;
      ef = (k == 2);
      @(negedge clk);
      show("flush_pend", k);
      n_tests++; if (bus.flush_o !== ef) begin n_fail++; $display("FAIL flush_pend_flush k=%0d got %b exp %b", k, bus.flush_o, ef); end
      n_tests++; if (bus.stall_o !== es) begin n_fail++; $display("FAIL flush_pend_stall k=%0d got %b exp %b", k, bus.stall_o, es); end
      next_cycle();
    end
  endtask

  task automatic test_flush_abort();
    logic [5:0] es;
    logic       ef, eb;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, k == 0, 6'd5, 0, 0, k == 1);
      es = (k == 0) ? 6'b001111 : 6'b000000;
      ef = (k == 1);
      eb = (k == 1);
      @(negedge clk);
      show("flush_abort", k);
      n_tests++; if (bus.stall_o !== es) begin n_fail++; $display("FAIL flush_abort_stall k=%0d got %b exp %b", k, bus.stall_o, es); end
      n_tests++; if (bus.flush_o !== ef) begin n_fail++; $display("FAIL flush_abort_flush k=%0d got %b exp %b", k, bus.flush_o, ef); end
      n_tests++; if (bus.busy_o !== eb) begin n_fail++; $display("FAIL flush_abort_busy k=%0d got %b exp %b", k, bus.busy_o, eb); end
      next_cycle();
    end
  endtask

  task automatic test_id_and_reset();
    logic [5:0] es;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rst = (k != 1);
      drive(k < 3, k == 0, 6'd3, 0, 0, 0);
      es = (k == 0) ? 6'b001111 : (k == 2) ? 6'b000111 : 6'b000000;
      @(negedge clk);
      show("id_reset", k);
      n_tests++; if (bus.stall_o !== es) begin n_fail++; $display("FAIL id_reset_stall k=%0d got %b exp %b", k, bus.stall_o, es); end
      n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL id_reset_busy k=%0d got %b exp 0", k, bus.busy_o); end
      n_tests++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL id_reset_flush k=%0d got %b exp 0", k, bus.flush_o); end
      next_cycle();
    end
    rst = 1'b1;
  endtask

  task automatic test_small_n_and_ignore();
    logic [5:0] n_tab [6];
    logic [5:0] es_tab [6];
    logic       eb_tab [6];
    n_tab  = '{6'd0, 6'd1, 6'd3, 6'd6, 6'd6, 6'd0};
    es_tab = '{6'b000000, 6'b000000, 6'b001111, 6'b001111, 6'b001111, 6'b000000};
    eb_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(0, k < 5, n_tab[k], 0, 0, 0);
      @(negedge clk);
      show("small_n", k);
      n_tests++; if (bus.stall_o !== es_tab[k]) begin n_fail++; $display("FAIL small_n_stall k=%0d got %b exp %b", k, bus.stall_o, es_tab[k]); end
      n_tests++; if (bus.busy_o !== eb_tab[k]) begin n_fail++; $display("FAIL small_n_busy k=%0d got %b exp %b", k, bus.busy_o, eb_tab[k]); end
      next_cycle();
    end
  endtask

  task automatic test_mem_during_mc();
    logic [5:0] es_tab [6];
    logic       eb_tab [6];
    es_tab = '{6'b001111, 6'b011111, 6'b011111, 6'b001111, 6'b001111, 6'b000000};
    eb_tab = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(0, k == 0, 6'd3, k == 1 || k == 2, 0, 0);
      @(negedge clk);
      show("mem_in_mc", k);
      n_tests++; if (bus.stall_o !== es_tab[k]) begin n_fail++; $display("FAIL mem_in_mc_stall k=%0d got %b exp %b", k, bus.stall_o, es_tab[k]); end
      n_tests++; if (bus.busy_o !== eb_tab[k]) begin n_fail++; $display("FAIL mem_in_mc_busy k=%0d got %b exp %b", k, bus.busy_o, eb_tab[k]); end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    logic [5:0] es;
    logic       ef, et;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 6'd0, 1, 0, 0);
`ifdef STALL_TIMEOUT_EN
      es = (k < 4) ? 6'b011111 : 6'b000000;
      ef = (k == 4);
      et = (k >= 4);
`else
      es = 6'b011111;
      ef = 1'b0;
      et = 1'b0;
`endif
      @(negedge clk);
      show("timeout", k);
      n_tests++; if (bus.stall_o !== es) begin n_fail++; $display("FAIL timeout_stall k=%0d got %b exp %b", k, bus.stall_o, es); end
      n_tests++; if (bus.flush_o !== ef) begin n_fail++; $display("FAIL timeout_flush k=%0d got %b exp %b", k, bus.flush_o, ef); end
      n_tests++; if (bus.timeout_o !== et) begin n_fail++; $display("FAIL timeout_flag k=%0d got %b exp %b", k, bus.timeout_o, et); end
      next_cycle();
    end
    drive(0, 0, 6'd0, 0, 0, 0);
    next_cycle();
  endtask

  // Model: m_owed counts EX-stall cycles still owed by the running op.
  task automatic test_random();
    int         m_owed = 0;
    int         m_wcnt = 0;
    bit         m_pend = 0, m_busy = 0, m_to = 0, m_supp = 0;
    bit         r, id, ms, mr, ma, fr, mem, flush, active, start;
    logic [5:0] n, es;
    logic       ef, eb, et;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r  = ($urandom % 64) != 0;
      id = ($urandom % 4) == 0;
      ms = ($urandom % 5) == 0;
      n  = 6'($urandom % 8);
      mr = ($urandom % 3) == 0;
      ma = ($urandom % 2) == 0;
      fr = ($urandom % 10) == 0;
      rst = r;
      drive(id, ms, n, mr, ma, fr);

      mem    = mr && !ma && !m_supp;
      flush  = !mem && (fr || m_pend);
      active = m_owed > 0;
      start  = ms && (n >= 6'd2) && !active;
      if (!r)                    es = 6'b000000;
      else if (mem)              es = 6'b011111;
      else if (flush)            es = 6'b000000;
      else if (active || start)  es = 6'b001111;
      else if (id)               es = 6'b000111;
      else                       es = 6'b000000;
      ef = r && flush;
      eb = r && m_busy;
      et = r && m_to;

      @(negedge clk);
      show("random", k);
      n_tests++; if (bus.stall_o !== es) begin n_fail++; $display("FAIL random_stall k=%0d got %b exp %b", k, bus.stall_o, es); end
      n_tests++; if (bus.flush_o !== ef) begin n_fail++; $display("FAIL random_flush k=%0d got %b exp %b", k, bus.flush_o, ef); end
      n_tests++; if (bus.busy_o !== eb) begin n_fail++; $display("FAIL random_busy k=%0d got %b exp %b", k, bus.busy_o, eb); end
      n_tests++; if (bus.timeout_o !== et) begin n_fail++; $display("FAIL random_timeout k=%0d got %b exp %b", k, bus.timeout_o, et); end
      next_cycle();

      if (!r) begin
        m_owed = 0; m_wcnt = 0; m_pend = 0; m_busy = 0; m_to = 0; m_supp = 0;
      end else begin
        if (mem) begin
          if (start) m_owed = int'(n) - 1;
          if (fr) m_pend = 1;
          m_busy = 1;
        end else if (flush) begin
          m_owed = 0; m_pend = 0; m_busy = 0;
        end else if (start) begin
          m_owed = int'(n) - 1; m_busy = 1;
        end else if (active) begin
          m_owed = m_owed - 1; m_busy = (m_owed > 0);
        end else begin
          m_busy = 0;
        end
`ifdef STALL_TIMEOUT_EN
        if (mem) begin
          m_wcnt = m_wcnt + 1;
          if (m_wcnt == int'(TO)) begin
            m_to = 1; m_supp = 1; m_pend = 1; m_wcnt = 0;
          end
        end else begin
          m_wcnt = 0;
        end
        if (!mr && !(mem && m_supp)) m_supp = 0;
`endif
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    drive(0, 0, 6'd0, 0, 0, 0);
    next_cycle();
    test_reset();
    test_mc_op();
    test_mem_stall();
    test_flush_pending();
    test_flush_abort();
    test_id_and_reset();
    test_small_n_and_ignore();
    test_mem_during_mc();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t required below 2000000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
